// File: rtl/yp_uart_pkg.sv
// Shared types and limits for the yp UART blocks.
package yp_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int MIN_DATA_WIDTH = 5;
    localparam int MAX_DATA_WIDTH = 9;

endpackage

// File: rtl/yp_sync_fifo.sv
// Synchronous FIFO with occupancy count; power-of-2 depth so pointers wrap naturally.
module yp_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;

endmodule

// File: rtl/yp_uart_tx_param.sv
// UART transmitter: FIFO-buffered input stream, runtime baud divisor, optional parity,
// 1 or 2 stop bits, back-to-back frames with no idle gap.
module yp_uart_tx_param
    import yp_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_data_valid,
    input  logic [DATA_WIDTH-1:0]         i_data_in,
    output logic                          o_data_ready,
    input  logic [DIV_W-1:0]              i_baud_div,
    input  logic                          i_parity_en,
    input  logic                          i_parity_odd,
    input  logic                          i_two_stop,
    output logic                          o_tx_data,
    output logic                          o_tx_busy,
    output logic                          o_tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int IDX_W = $clog2(MAX_DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < MIN_DATA_WIDTH || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_width
        $error("yp_uart_tx_param: DATA_WIDTH must be within 5..9");
    end

    // Reset asserts asynchronously and releases two clocks later.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    // Input stream: a word transfers on a clock where valid and ready are both high;
    // ready is simply "FIFO not full" and never depends on valid.
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign o_data_ready = !fifo_full;
    assign push         = i_data_valid && !fifo_full;

    yp_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (i_data_in),
        .pop     (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    tx_state_e             state;
    tx_state_e             state_next;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic [DIV_W-1:0]      cnt_q;
    logic [DIV_W-1:0]      div_q;
    logic                  par_en_q;
    logic                  two_stop_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  bit_end;
    logic                  last_stop;

    assign bit_end   = (cnt_q == '0);
    assign last_stop = (idx_q == IDX_W'(two_stop_q));

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && idx_q == LAST_DATA) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end && last_stop) state_next = fifo_empty ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_tx_data = 1'b1;
        o_tx_busy = 1'b1;
        o_tx_done = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                o_tx_busy = 1'b0;
                pop       = !fifo_empty;
            end
            START:  o_tx_data = 1'b0;
            DATA:   o_tx_data = shift_q[0];
            PARITY: o_tx_data = par_q;
            STOP: begin
                o_tx_done = bit_end && last_stop;
                pop       = bit_end && last_stop && !fifo_empty;
            end
            default: o_tx_busy = 1'b0;
        endcase
    end

    // Frame settings are latched at pop so mid-frame input changes only affect the next frame.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            par_q      <= 1'b0;
            cnt_q      <= '0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            idx_q      <= '0;
        end else if (pop) begin
            shift_q    <= fifo_rdata;
            par_q      <= i_parity_odd;
            cnt_q      <= i_baud_div;
            div_q      <= i_baud_div;
            par_en_q   <= i_parity_en;
            two_stop_q <= i_two_stop;
            idx_q      <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                cnt_q <= div_q;
                case (state)
                    DATA: begin
                        par_q   <= par_q ^ shift_q[0];
                        shift_q <= shift_q >> 1;
                        idx_q   <= (idx_q == LAST_DATA) ? '0 : idx_q + IDX_W'(1);
                    end
                    STOP:    idx_q <= idx_q + IDX_W'(1);
                    default: idx_q <= idx_q;
                endcase
            end else begin
                cnt_q <= cnt_q - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_yp_uart_tx_param.sv
// Bench for yp_uart_tx_param: table vectors, hand-written corner sequences, random traffic
// checked by a frame-level line monitor.
module tb_yp_uart_tx_param;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          data_valid;
    logic [DW-1:0] data_in;
    logic          data_ready;
    logic [15:0]   baud_div;
    logic          parity_en;
    logic          parity_odd;
    logic          two_stop;
    logic          tx_data;
    logic          tx_busy;
    logic          tx_done;
    logic [2:0]    fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int busy_falls = 0;
    logic busy_prev = 1'b0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         pe;
        bit         po;
        bit         ts;
        int         exp_len;
        bit         exp_par;
    } vec_t;

    vec_t vecs[7];

    yp_uart_tx_param #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .DIV_W      (16)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_data_valid (data_valid),
        .i_data_in    (data_in),
        .o_data_ready (data_ready),
        .i_baud_div   (baud_div),
        .i_parity_en  (parity_en),
        .i_parity_odd (parity_odd),
        .i_two_stop   (two_stop),
        .o_tx_data    (tx_data),
        .o_tx_busy    (tx_busy),
        .o_tx_done    (tx_done),
        .o_fifo_level (fifo_level)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic push_word(input logic [DW-1:0] d);
        int g = 0;
        data_valid = 1'b1;
        data_in    = d;
        while (!data_ready && g < 2000) begin
            tick();
            g++;
        end
        check("push_ready_timeout", data_ready, 1'b1);
        if (data_ready) exp_q.push_back(d);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int g = 0;
        while (!tx_busy && g < 200) begin
            tick();
            g++;
        end
        check("busy_start_timeout", tx_busy, 1'b1);
    endtask

    task automatic count_to_done(input int target, output int n);
        n = 0;
        while (done_cnt < target && n < 5000) begin
            tick();
            n++;
        end
    endtask

    // Counters sampled mid-cycle
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_busy) busy_cnt++;
        if (busy_prev && !tx_busy) busy_falls++;
        busy_prev = tx_busy;
    end

    // Line monitor: expected frame built from the word and the settings seen at start.
    task automatic check_frame();
        logic [DW-1:0] d;
        int  div;
        bit  bits[$];
        bit  aborted = 0;
        int  nb;
        div = int'(baud_div);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 32'd1, 32'd0);
            return;
        end
        d = exp_q.pop_front();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (parity_en) bits.push_back((^d) ^ parity_odd);
        bits.push_back(1'b1);
        if (two_stop) bits.push_back(1'b1);
        nb = bits.size();
        for (int b = 0; b < nb && !aborted; b++) begin
            for (int k = 0; k <= div && !aborted; k++) begin
                if (!(b == 0 && k == 0)) @(negedge clk);
                if (!rstn) begin
                    aborted = 1;
                end else begin
                    check("tx_line", tx_data, bits[b]);
                    check("busy_in_frame", tx_busy, 1'b1);
                    check("done_pulse", tx_done, (b == nb - 1 && k == div));
                end
            end
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx_data === 1'b0) check_frame();
        end
    end

    initial begin : stim
        int n;
        int base;
        int base_busy;
        int base_falls;
        int pushed;
        int g;
        logic par_seen;

        vecs[0] = '{8'hA5, 3, 0, 0, 0, 40, 0};
        vecs[1] = '{8'h07, 3, 1, 0, 0, 44, 1};
        vecs[2] = '{8'h07, 3, 1, 1, 0, 44, 0};
        vecs[3] = '{8'h00, 1, 1, 0, 1, 24, 0};
        vecs[4] = '{8'hFF, 0, 1, 1, 1, 12, 1};
        vecs[5] = '{8'h5A, 2, 0, 0, 1, 33, 0};
        vecs[6] = '{8'h80, 5, 1, 0, 0, 66, 1};

        rstn = 1'b1;
        data_valid = 1'b0;
        data_in = '0;
        baud_div = 16'd3;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        #1 rstn = 1'b0;
        #2;
        check("rst_tx", tx_data, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_ready", data_ready, 1'b1);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (4) tick();
        check("idle_tx", tx_data, 1'b1);
        check("idle_busy", tx_busy, 1'b0);

        // Table vectors: one frame each, length and parity bit from the table
        for (int v = 0; v < 7; v++) begin
            baud_div   = 16'(vecs[v].div);
            parity_en  = vecs[v].pe;
            parity_odd = vecs[v].po;
            two_stop   = vecs[v].ts;
            base = done_cnt;
            push_word(vecs[v].data);
            wait_busy();
            n = 0;
            par_seen = 1'bx;
            while (done_cnt == base && n < 5000) begin
                if (n == 9 * (vecs[v].div + 1)) par_seen = tx_data;
                tick();
                n++;
            end
            check("frame_len", n + 1, vecs[v].exp_len);
            if (vecs[v].pe) check("parity_bit", par_seen, vecs[v].exp_par);
            tick();
            check("idle_after_frame", tx_busy, 1'b0);
            check("level_after_frame", fifo_level, 3'd0);
        end

        // Two stop bits, back-to-back: 2*44 clocks with no gap
        baud_div = 16'd3;
        parity_en = 1'b0;
        two_stop = 1'b1;
        base = done_cnt;
        push_word(8'h00);
        push_word(8'hFF);
        wait_busy();
        count_to_done(base + 2, n);
        check("two_stop_b2b_len", n, 87);

        // Burst: five accepted, ready low while full, five contiguous frames
        two_stop = 1'b0;
        tick();
        base = done_cnt;
        base_busy = busy_cnt;
        base_falls = busy_falls;
        for (int i = 0; i < 5; i++) push_word(8'(8'h31 + i));
        check("burst_level_full", fifo_level, 3'd4);
        data_valid = 1'b1;
        data_in = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            check("burst_ready_low", data_ready, 1'b0);
            tick();
        end
        data_valid = 1'b0;
        count_to_done(base + 5, n);
        tick();
        check("burst_done_count", done_cnt - base, 5);
        check("burst_busy_cycles", busy_cnt - base_busy, 200);
        check("burst_busy_falls", busy_falls - base_falls, 1);
        check("burst_idle", tx_busy, 1'b0);

        // Reset during DATA bit 3 with a second word queued
        base = done_cnt;
        push_word(8'h96);
        push_word(8'h11);
        wait_busy();
        repeat (17) tick();
        rstn = 1'b0;
        #1;
        check("midrst_tx", tx_data, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_level", fifo_level, 3'd0);
        check("midrst_done", tx_done, 1'b0);
        exp_q.delete();
        repeat (3) tick();
        check("midrst_no_done", done_cnt - base, 0);
        rstn = 1'b1;
        repeat (6) tick();
        check("postrst_idle", tx_busy, 1'b0);
        check("postrst_level", fifo_level, 3'd0);
        base = done_cnt;
        push_word(8'h3C);
        wait_busy();
        count_to_done(base + 1, n);
        check("postrst_frame_len", n, 39);

        // Divisor change mid-frame: 10 clocks at div 0, then 80 at div 7
        tick();
        baud_div = 16'd0;
        base = done_cnt;
        push_word(8'hC3);
        push_word(8'h5E);
        wait_busy();
        n = 0;
        while (done_cnt < base + 2 && n < 5000) begin
            if (n == 3) baud_div = 16'd7;
            tick();
            n++;
        end
        check("div_change_len", n, 89);
        tick();

        // Random traffic with random settings, changed at any time
        base = done_cnt;
        pushed = 0;
        for (int t = 0; t < 700; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                baud_div   = 16'($urandom_range(0, 3));
                parity_en  = 1'($urandom_range(0, 1));
                parity_odd = 1'($urandom_range(0, 1));
                two_stop   = 1'($urandom_range(0, 1));
            end
            data_valid = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            if (data_valid && data_ready) begin
                exp_q.push_back(data_in);
                pushed++;
            end
            tick();
        end
        data_valid = 1'b0;
        g = 0;
        while ((tx_busy || fifo_level != 0) && g < 20000) begin
            tick();
            g++;
        end
        tick();
        check("rand_drained", tx_busy, 1'b0);
        check("rand_scoreboard_empty", exp_q.size(), 0);
        check("rand_done_count", done_cnt - base, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
